keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 3x3 active-low keypad matrix for the WAM board, synchronises and debounces the columns,
//  and emits the 4-bit key code {col[1:0],row[1:0]} that key_decoder maps to key numbers 0..8.
//  Produces a stable code, a level valid flag and one-cycle press/release strobes for the game FSM.
//  Idle or no-key code is 4'b1111, which decodes to 9 ("no key").
// PARAMETERS
//  SCAN_DIV        50000  clk cycles each row is driven (1 ms @ 50 MHz); must be >= 4
//  DEBOUNCE_SCANS  4      consecutive identical frames required to accept a result; must be >= 1
// PORTS
//  clk          in   1  single system clock, rising edge
//  resetn       in   1  asynchronous, active-low reset
//  col_n        in   3  keypad columns, active-low, pulled up, asynchronous to clk
//  row_n        out  3  keypad row drive, one-hot low (3'b110 = row 0)
//  key          out  4  debounced code: [3:2]=column 0..2, [1:0]=row 0..2; 4'hF = none
//  key_valid    out  1  1 while key != 4'hF
//  key_press    out  1  one-cycle pulse when a new valid code is accepted
//  key_release  out  1  one-cycle pulse when a previously valid code is left
// BEHAVIOUR
//  Reset (async, immediate): row_n=3'b110, key=4'hF, key_valid=0, key_press=0, key_release=0,
//  row index=0, divider=0, frame raw=4'hF, prev raw=4'hF, stable count=0. No pulses during or out of reset.
//  col_n passes through a 2-flop synchroniser before any use, which adds 2 cycles of latency.
//  Divider counts 0..SCAN_DIV-1 while one row is driven. On count SCAN_DIV-1 (SAMPLE), the synced columns
//  for the current row are sampled, then the row advances 0->1->2->0 and the divider wraps to 0.
//  Frame raw: while a frame runs, the first pressed position by priority (lowest row, then lowest column)
//  is latched. Later hits in the same frame are ignored. No hit gives 4'hF. The latch is cleared at frame start.
//  EVAL happens on the cycle after the row-2 SAMPLE:
//   - raw == prev raw: stable count++, saturating at DEBOUNCE_SCANS-1.
//   - otherwise: stable count=0, prev raw=raw.
//   - accepted when raw == prev raw and stable count reaches DEBOUNCE_SCANS-1. With DEBOUNCE_SCANS=1,
//     every frame is accepted.
//   - accepted result != key: key<=result next cycle.
//       key_release pulses if old key != 4'hF.
//       key_press pulses if new result != 4'hF.
//       Switching A->B directly (both valid) pulses both in the same cycle.
//   - accepted result == key: no change, no pulse. A held key never re-fires.
//  key_valid is registered together with key and always equals (key != 4'hF).
//  Latency press->key_press: at most (DEBOUNCE_SCANS+1)*3*SCAN_DIV + 4 cycles.
//  Ghosting and multi-key cases: only the priority key is reported. No error flag.
//  Invalid codes (row or column = 3) are never produced apart from 4'hF.
//  Reset mid-debounce or mid-press clears all state. A key still held is reported again after a full
//  debounce, with a fresh key_press.
// STRUCTURE
//  Shared include wam_keypad_defs.vh holds:
//   KEY_NONE=4'hF, KEY_ROW_LSB=0, KEY_COL_LSB=2, NUM_ROWS=3, NUM_COLS=3.
//   key_decoder should adopt KEY_NONE as well.
//  Sub-module sync_2ff (parameterised width, async active-low reset to all-ones) for col_n.
//  Control: 2-bit row counter, divider, FSM {SCAN, EVAL}. SCAN covers drive and SAMPLE; EVAL lasts 1 cycle.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3, keypad model: col_n low if the driven row's key is pressed)
//  1 Apply reset -> row_n=3'b110, key=4'hF, key_valid=0, no pulses; rows cycle 110,101,011 every 4 clk.
//  2 Hold row1/col2 -> key=4'b1001 (decodes 5) and key_valid=1 after 3 stable frames, exactly one key_press.
//  3 Bounce row0/col0 on/off for 2 frames, then hold -> no output until 3 identical frames,
//    then key=4'b0000 with one key_press.
//  4 Hold row2/col0 and row0/col1 together -> key=4'b0100. Release row0/col1 ->
//    key=4'b0010 with key_release and key_press in the same cycle.
//  5 Release all -> key=4'hF and key_valid=0 after 3 frames, one key_release, no key_press.
//  6 Assert resetn=0 mid-debounce and mid-hold -> outputs reset in the same cycle with no pulse.
//    Continue holding -> one fresh key_press after full debounce.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared constants, types and small helpers for the 3x3 WAM keypad scanner.
// Key code layout is {col[1:0], row[1:0]}; KEY_NONE doubles as "no key" for key_decoder.
package keypad_scanner_pkg;

  localparam logic [3:0] KEY_NONE    = 4'hF;
  localparam int         KEY_ROW_LSB = 0;
  localparam int         KEY_COL_LSB = 2;
  localparam int         NUM_ROWS    = 3;
  localparam int         NUM_COLS    = 3;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } scan_state_t;

  function automatic logic [3:0] make_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    k = '0;
    k[KEY_ROW_LSB +: 2] = row;
    k[KEY_COL_LSB +: 2] = col;
    return k;
  endfunction

  // One-hot-low row drive; row 0 is 3'b110.
  function automatic logic [2:0] row_drive(input logic [1:0] row);
    return ~(3'b001 << row);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key result seen by the game FSM.
// key_press/key_release are single-cycle strobes; key/key_valid are levels that change together.
interface keypad_scanner_if;
  logic [2:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_press;
  logic       key_release;

  modport master (
    input  col_n,
    output row_n, key, key_valid, key_press, key_release
  );

  modport slave (
    output col_n,
    input  row_n, key, key_valid, key_press, key_release
  );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (idle for pulled-up lines).
module keypad_scanner_sync_2ff #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 active-low keypad scanner: drives rows in turn, latches the priority hit per frame,
// debounces whole frames and emits a stable key code with press/release strobes.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  keypad_scanner_if.master  kp,
  output scan_state_t       dbg_state
);

  localparam int         DW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int         CW       = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [1:0]    ROW_LAST = 2'(NUM_ROWS - 1);

  scan_state_t   state;
  logic [DW-1:0] div;
  logic [1:0]    row_idx;
  logic [2:0]    row_n_q;
  logic [2:0]    col_s;
  logic [3:0]    frame_raw;
  logic [3:0]    prev_raw;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic [3:0]    key_q;
  logic          key_valid_q;
  logic          key_press_q;
  logic          key_release_q;
  logic          row_hit;
  logic [1:0]    hit_col;
  logic [3:0]    latched_next;

  keypad_scanner_sync_2ff #(.WIDTH(NUM_COLS)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (kp.col_n),
    .q      (col_s)
  );

  // Lowest pressed column in the currently driven row wins.
  always_comb begin
    row_hit = 1'b0;
    hit_col = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) begin
        row_hit = 1'b1;
        hit_col = 2'(c);
      end
    end
  end

  // Rows are sampled in ascending order, so keeping the first hit keeps the lowest row.
  always_comb begin
    latched_next = frame_raw;
    if (frame_raw == KEY_NONE && row_hit) latched_next = make_key(row_idx, hit_col);
  end

  always_comb begin
    cnt_next = '0;
    if (frame_raw == prev_raw) cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
  end

  // With a single required frame CNT_MAX is 0, so every frame is accepted.
  assign accept = (cnt_next == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_SCAN;
      div           <= '0;
      row_idx       <= 2'd0;
      row_n_q       <= 3'b110;
      frame_raw     <= KEY_NONE;
      prev_raw      <= KEY_NONE;
      stable_cnt    <= '0;
      key_q         <= KEY_NONE;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;

      if (div == DIV_LAST) begin
        div       <= '0;
        frame_raw <= latched_next;
        if (row_idx == ROW_LAST) begin
          row_idx <= 2'd0;
          row_n_q <= row_drive(2'd0);
          state   <= ST_EVAL;
        end else begin
          row_idx <= row_idx + 2'd1;
          row_n_q <= row_drive(row_idx + 2'd1);
        end
      end else begin
        div <= div + 1'b1;
      end

      // EVAL overlaps the first cycle of the next frame's row 0, long before its SAMPLE.
      if (state == ST_EVAL) begin
        state      <= ST_SCAN;
        frame_raw  <= KEY_NONE;
        prev_raw   <= frame_raw;
        stable_cnt <= cnt_next;
        if (accept && frame_raw != key_q) begin
          key_q         <= frame_raw;
          key_valid_q   <= (frame_raw != KEY_NONE);
          key_release_q <= (key_q != KEY_NONE);
          key_press_q   <= (frame_raw != KEY_NONE);
        end
      end
    end
  end

  assign kp.row_n       = row_n_q;
  assign kp.key         = key_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_press   = key_press_q;
  assign kp.key_release = key_release_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 3x3 matrix model (SCAN_DIV=4, 3 frames).
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic        clk;
  logic        resetn;
  logic [8:0]  pressed;   // index = row*3 + col
  scan_state_t dbg_state;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .kp        (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a column is pulled low when the driven row holds a pressed key there.
  always_comb begin
    logic [2:0] c_n;
    c_n = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && !bus.row_n[r]) c_n[c] = 1'b0;
    bus.col_n = c_n;
  end

  // scoreboard state
  int         n_checks = 0;
  int         n_fail   = 0;
  int         press_cnt = 0, release_cnt = 0, both_cnt = 0, bad_valid_cnt = 0;
  int         p0, r0, b0;
  logic [3:0] press_log[$];
  logic [3:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.key_press) begin
      press_cnt++;
      press_log.push_back(bus.key);
    end
    if (bus.key_release) release_cnt++;
    if (bus.key_press && bus.key_release) both_cnt++;
    if (bus.key_valid !== (bus.key != 4'hF)) bad_valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    p0 = press_cnt;
    r0 = release_cnt;
    b0 = both_cnt;
  endtask

  task automatic check_deltas(input string tag, input int dp, input int dr, input int db);
    check({tag, "_press_cnt"},   press_cnt - p0,   dp);
    check({tag, "_release_cnt"}, release_cnt - r0, dr);
    check({tag, "_both_cnt"},    both_cnt - b0,    db);
  endtask

  task automatic check_key(input string tag, input logic [3:0] k, input logic v);
    check({tag, "_key"},   bus.key,       k);
    check({tag, "_valid"}, bus.key_valid, v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_n"},   bus.row_n,       3'b110);
    check({tag, "_key"},     bus.key,         4'hF);
    check({tag, "_valid"},   bus.key_valid,   1'b0);
    check({tag, "_press"},   bus.key_press,   1'b0);
    check({tag, "_release"}, bus.key_release, 1'b0);
  endtask

  initial begin
    logic [2:0] exp_row;
    resetn  = 1'b0;
    pressed = 9'b0;

    // 1: reset values, then row rotation every 4 clocks
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_state", dbg_state, ST_SCAN);
    resetn = 1'b1;
    snap();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      case ((k / 4) % 3)
        0:       exp_row = 3'b110;
        1:       exp_row = 3'b101;
        default: exp_row = 3'b011;
      endcase
      check("row_scan", bus.row_n, exp_row);
    end
    check_key("idle", 4'hF, 1'b0);

    // 2: hold row1/col2 -> code 4'b1001
    snap();
    pressed[1*3 + 2] = 1'b1;
    wait_cycles(20);
    check_key("k5_early", 4'hF, 1'b0);
    wait_cycles(40);
    exp_q.push_back(4'b1001);
    check_key("k5_held", 4'b1001, 1'b1);
    check_deltas("k5", 1, 0, 0);

    pressed = 9'b0;
    snap();
    wait_cycles(60);
    check_key("k5_rel", 4'hF, 1'b0);
    check_deltas("k5_rel", 0, 1, 0);

    // 3: bounce row0/col0 for two frames, then hold
    snap();
    for (int i = 0; i < 4; i++) begin
      pressed[0] = ~pressed[0];
      wait_cycles(12);
    end
    check_key("bounce", 4'hF, 1'b0);
    check_deltas("bounce", 0, 0, 0);
    pressed[0] = 1'b1;
    wait_cycles(60);
    exp_q.push_back(4'b0000);
    check_key("k0_held", 4'b0000, 1'b1);
    check_deltas("k0", 1, 0, 0);

    // 4: row2/col0 + row0/col1 together, then drop row0/col1
    snap();
    pressed = 9'b0;
    pressed[2*3 + 0] = 1'b1;
    pressed[0*3 + 1] = 1'b1;
    wait_cycles(60);
    exp_q.push_back(4'b0100);
    check_key("multi", 4'b0100, 1'b1);
    check_deltas("multi", 1, 1, 1);
    snap();
    pressed[0*3 + 1] = 1'b0;
    wait_cycles(60);
    exp_q.push_back(4'b0010);
    check_key("switch", 4'b0010, 1'b1);
    check_deltas("switch", 1, 1, 1);

    // 5: release all
    snap();
    pressed = 9'b0;
    wait_cycles(20);
    check_key("rel_early", 4'b0010, 1'b1);
    wait_cycles(40);
    check_key("rel_all", 4'hF, 1'b0);
    check_deltas("rel_all", 0, 1, 0);

    // 6: reset mid-debounce, then mid-hold; key stays pressed throughout
    snap();
    pressed[1*3 + 1] = 1'b1;
    wait_cycles(20);
    check_key("deb_pre", 4'hF, 1'b0);
    #1 resetn = 1'b0;
    #1 check_reset_outputs("rst_deb");
    wait_cycles(3);
    resetn = 1'b1;
    check_deltas("rst_deb", 0, 0, 0);
    wait_cycles(60);
    exp_q.push_back(4'b0101);
    check_key("k4_after_rst", 4'b0101, 1'b1);
    check_deltas("k4_after_rst", 1, 0, 0);

    snap();
    #3 resetn = 1'b0;
    #1 check_reset_outputs("rst_hold");
    wait_cycles(3);
    resetn = 1'b1;
    check_deltas("rst_hold", 0, 0, 0);
    snap();
    wait_cycles(60);
    exp_q.push_back(4'b0101);
    check_key("k4_refire", 4'b0101, 1'b1);
    check_deltas("k4_refire", 1, 0, 0);

    // scoreboard: every key_press carried the expected code, in order
    check("press_log_size", press_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < press_log.size()) check("press_code", press_log[i], exp_q[i]);
    check("valid_tracks_key", bad_valid_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
